// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states and
// sizing helpers.
package mult_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width of a counter able to hold the values 0..w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain WIDTH-bit ripple-carry adder with carry-out, used by the multiplier
// for its per-step accumulate.
module adder_nbit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   logic [WIDTH-1:0] sum_s;
   logic             carry_s;

   // Bit-serial carry chain, LSB first.
   always_comb begin
      sum_s   = {WIDTH{1'b0}};
      carry_s = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_s[i] = a_i[i] ^ b_i[i] ^ carry_s;
         carry_s  = (a_i[i] & b_i[i]) | (a_i[i] & carry_s) | (b_i[i] & carry_s);
      end
   end

   assign sum_o  = sum_s;
   assign cout_o = carry_s;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier: WIDTH shift-add steps on operand magnitudes,
// with the sign applied once when the result is published.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = cnt_width(WIDTH);

   state_e               state_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CW-1:0]        cnt_q;
   logic                 sign_q;
   logic                 busy_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   product_q;

   logic                 mode_s;
   logic                 a_neg_s;
   logic                 b_neg_s;
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic [WIDTH-1:0]     sum_s;
   logic                 cout_s;
   logic [2*WIDTH-1:0]   acc_step_s;
   logic [2*WIDTH-1:0]   final_s;

   // Magnitudes are kept unsigned in WIDTH bits, so the most negative value maps exactly.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign mode_s  = (SIGNED_EN != 1'b0) && signed_mode;
   assign a_neg_s = mode_s && a[WIDTH-1];
   assign b_neg_s = mode_s && b[WIDTH-1];
   assign a_mag_s = a_neg_s ? neg_w(a) : a;
   assign b_mag_s = b_neg_s ? neg_w(b) : b;

   adder_nbit #(.WIDTH(WIDTH)) u_adder (
      .a_i    (acc_q[2*WIDTH-1:WIDTH]),
      .b_i    (mcand_q),
      .sum_o  (sum_s),
      .cout_o (cout_s)
   );

   // One shift-add step; the multiplier is consumed from the low half as it shifts out.
   always_comb begin
      acc_step_s = {1'b0, acc_q[2*WIDTH-1:1]};
      if (acc_q[0]) begin
         acc_step_s = {cout_s, sum_s, acc_q[WIDTH-1:1]};
      end else begin
         acc_step_s = {1'b0, acc_q[2*WIDTH-1:1]};
      end
   end

   assign final_s = (sign_q && (acc_step_s != {(2*WIDTH){1'b0}}))
                    ? ((~acc_step_s) + {{(2*WIDTH-1){1'b0}}, 1'b1})
                    : acc_step_s;

   // Control FSM with registered outputs; reset clears all state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mcand_q   <= {WIDTH{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         cnt_q     <= {CW{1'b0}};
         sign_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= {(2*WIDTH){1'b0}};
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  mcand_q <= a_mag_s;
                  acc_q   <= {{WIDTH{1'b0}}, b_mag_s};
                  cnt_q   <= {CW{1'b0}};
                  sign_q  <= a_neg_s ^ b_neg_s;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc_q <= acc_step_s;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  product_q <= final_s;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule
